// File: rtl/obstacle_motion_sched.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_motion_sched
// Brief    : Per-frame motion scheduler for N obstacle sprite cores. At each
//            vertical-blank start it walks every obstacle in index order,
//            moves it left by 'speed' pixels (respawning at H_RES when it
//            would underflow) and writes x0 then y0 into that core's
//            register space over the shared video-slot write bus.
// Options  : OBSTACLE_RAND_Y_EN - when defined, a free-running 8-bit LFSR
//            randomises y0 of an obstacle each time it respawns.
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_motion_sched #(
  parameter int N         = 2,
  parameter int H_RES     = 640,
  parameter int V_TRIG    = 480,
  parameter int X_INIT    = 640,
  parameter int X_SPACING = 320,
  parameter int Y_BASE    = 400
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          en,
  input  logic [3:0]    speed,
  output logic [N-1:0]  cs,
  output logic          write,
  output logic [13:0]   addr,
  output logic [31:0]   wr_data,
  output logic          busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [13:0]      C_ADDR_X   = 14'h2001;
  localparam logic [13:0]      C_ADDR_Y   = 14'h2002;
  localparam logic [10:0]      C_H_RES    = 11'(H_RES);
  localparam logic [10:0]      C_V_TRIG   = 11'(V_TRIG);
  localparam logic [10:0]      C_Y_BASE   = 11'(Y_BASE);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N - 1);
  localparam logic [N-1:0]     C_CS_ONE   = N'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WR_X = 2'd2,
    S_WR_Y = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;

  logic             r_cond_d;
  logic             w_cond;
  logic             w_trig;

  logic [10:0]      r_xpos [N];
  logic [10:0]      w_xpos_cur;
  logic [10:0]      w_ypos_cur;
  logic [11:0]      w_sum;
  logic             w_borrow;
  logic             w_calc;

  logic [N-1:0]     w_cs_d;
  logic             w_write_d;
  logic [13:0]      w_addr_d;
  logic [31:0]      w_data_d;

  // --------------------------------------------------------------------------
  // Frame trigger: one pulse on the first cycle the counter sits at (0,V_TRIG),
  // however many clocks the pixel counter dwells there.
  // --------------------------------------------------------------------------
  assign w_cond = (x == 11'd0) && (y == C_V_TRIG);
  assign w_trig = w_cond & ~r_cond_d;

  // Delay the trigger condition so only its rising edge starts a sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cond_d <= 1'b0;
    end else begin
      r_cond_d <= w_cond;
    end
  end

  // --------------------------------------------------------------------------
  // Position arithmetic for the obstacle currently selected by r_idx. The
  // 12-bit subtraction exposes the borrow, which is the respawn condition;
  // landing exactly on 0 is a legal position and is kept.
  // --------------------------------------------------------------------------
  assign w_xpos_cur = r_xpos[r_idx];
  assign w_sum      = {1'b0, w_xpos_cur} - {8'b0, speed};
  assign w_borrow   = w_sum[11];
  assign w_calc     = (r_state == S_CALC);

  for (genvar gi = 0; gi < N; gi++) begin : g_xpos
    localparam logic [10:0] C_X_RST = 11'(X_INIT + gi * X_SPACING);

    // Horizontal position of obstacle gi, updated only in its own CALC slot.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_xpos[gi] <= C_X_RST;
      end else if (w_calc && (r_idx == IDX_W'(gi))) begin
        r_xpos[gi] <= w_borrow ? C_H_RES : w_sum[10:0];
      end
    end
  end

`ifdef OBSTACLE_RAND_Y_EN
  logic [7:0]  r_lfsr;
  logic        w_lfsr_fb;
  logic [10:0] r_yval [N];

  // Fibonacci taps 8,6,5,4 shifted towards the MSB; runs every clock so the
  // respawn height depends on when the respawn happens.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Free-running height randomiser.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_yval
    // New height for obstacle gi whenever it respawns; range Y_BASE-63..Y_BASE.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_yval[gi] <= C_Y_BASE;
      end else if (w_calc && (r_idx == IDX_W'(gi)) && w_borrow) begin
        r_yval[gi] <= C_Y_BASE - {5'b0, r_lfsr[5:0]};
      end
    end
  end

  assign w_ypos_cur = r_yval[r_idx];
`else
  // Fixed track height: every obstacle runs along the same line.
  assign w_ypos_cur = C_Y_BASE;
`endif

  // --------------------------------------------------------------------------
  // Sweep control
  // --------------------------------------------------------------------------

  // State and obstacle-index registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state logic: CALC -> WR_X -> WR_Y per obstacle; triggers arriving
  // mid-sweep are dropped, and en only gates the start of a sweep.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_trig && en) begin
          w_state_next = S_CALC;
          w_idx_next   = '0;
        end
      end
      S_CALC: begin
        w_state_next = S_WR_X;
      end
      S_WR_X: begin
        w_state_next = S_WR_Y;
      end
      S_WR_Y: begin
        if (r_idx == C_IDX_LAST) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end else begin
          w_state_next = S_CALC;
          w_idx_next   = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Slot bus values for the current state; they appear one clock later.
  always_comb begin
    w_cs_d    = '0;
    w_write_d = 1'b0;
    w_addr_d  = '0;
    w_data_d  = '0;
    case (r_state)
      S_WR_X: begin
        w_cs_d    = C_CS_ONE << r_idx;
        w_write_d = 1'b1;
        w_addr_d  = C_ADDR_X;
        w_data_d  = {21'b0, w_xpos_cur};
      end
      S_WR_Y: begin
        w_cs_d    = C_CS_ONE << r_idx;
        w_write_d = 1'b1;
        w_addr_d  = C_ADDR_Y;
        w_data_d  = {21'b0, w_ypos_cur};
      end
      default: begin
        w_cs_d    = '0;
        w_write_d = 1'b0;
        w_addr_d  = '0;
        w_data_d  = '0;
      end
    endcase
  end

  // Registered slot bus; reset kills any pending strobe of an abandoned sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs      <= '0;
      write   <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
    end else begin
      cs      <= w_cs_d;
      write   <= w_write_d;
      addr    <= w_addr_d;
      wr_data <= w_data_d;
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_obstacle_motion_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_motion_sched
// Brief    : Self-checking bench for obstacle_motion_sched. Expected slot
//            writes are queued when a frame trigger is driven and popped as
//            the strobes appear; frame rows with known final positions drive
//            the main sequence, followed by hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_motion_sched;

  localparam int N      = 2;
  localparam int H_RES  = 640;
  localparam int V_TRIG = 480;
  localparam int Y_BASE = 400;
`ifdef OBSTACLE_RAND_Y_EN
  localparam bit RND_Y = 1'b1;
`else
  localparam bit RND_Y = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x;
  logic [10:0]   y;
  logic          en;
  logic [3:0]    speed;
  logic [N-1:0]  cs;
  logic          write;
  logic [13:0]   addr;
  logic [31:0]   wr_data;
  logic          busy;

  always #5 clk = ~clk;

  obstacle_motion_sched #(
    .N(N), .H_RES(H_RES), .V_TRIG(V_TRIG),
    .X_INIT(640), .X_SPACING(320), .Y_BASE(Y_BASE)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .en(en), .speed(speed),
    .cs(cs), .write(write), .addr(addr), .wr_data(wr_data), .busy(busy)
  );

  typedef struct {
    logic [N-1:0] cs;
    logic [13:0]  addr;
    logic [31:0]  data;
    bit           rnd;
    int           idx;
  } exp_t;

  typedef struct {
    int          reps;
    logic [3:0]  spd;
    logic        en;
    int          ex0;
    int          ex1;
  } row_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int          busy_cnt = 0;
  int          mx [N];
  int          my [N];
  logic [10:0] last_x [N];
  logic [31:0] mon_exp;
  logic [7:0]  tb_lf;
  logic [7:0]  lf_hist [3];
  row_t        rows [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Independent copy of the height randomiser, with the last three pre-edge
  // values kept so a y write can be matched to its CALC edge.
  always @(posedge clk) begin
    if (reset === 1'b0) tb_lf <= 8'hA5;
    else tb_lf <= {tb_lf[6:0], tb_lf[7] ^ tb_lf[5] ^ tb_lf[4] ^ tb_lf[3]};
    lf_hist[0] <= tb_lf;
    lf_hist[1] <= lf_hist[0];
    lf_hist[2] <= lf_hist[1];
  end

  // Bus monitor: every strobe must match the head of the scoreboard, and the
  // bus must be all-zero between strobes.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      if (write === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write cs=%b addr=%h data=%0d required=none", cs, addr, wr_data);
        end else begin
          mon_e = sbq.pop_front();
          mon_exp = mon_e.data;
          if (mon_e.rnd) begin
            mon_exp = 32'(Y_BASE - int'(lf_hist[2][5:0]));
            my[mon_e.idx] = int'(mon_exp);
          end
          check("wr_cs", 64'(cs), 64'(mon_e.cs));
          check("wr_addr", 64'(addr), 64'(mon_e.addr));
          check("wr_data", 64'(wr_data), 64'(mon_exp));
          if (mon_e.addr == 14'h2001) last_x[mon_e.idx] = wr_data[10:0];
        end
      end else begin
        check("idle_bus", {cs, addr, wr_data}, 64'd0);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 640 + i * 320;
      my[i] = Y_BASE;
    end
  endtask

  // Queue the x/y writes one sweep at speed spd should produce.
  task automatic push_frame(input logic [3:0] spd, input int count);
    exp_t e;
    bit   rsp;
    for (int i = 0; i < count; i++) begin
      rsp   = (mx[i] < int'(spd));
      mx[i] = rsp ? H_RES : mx[i] - int'(spd);
      e.cs   = N'(1) << i;
      e.idx  = i;
      e.addr = 14'h2001;
      e.data = 32'(mx[i]);
      e.rnd  = 1'b0;
      sbq.push_back(e);
      if (count == N) begin
        e.addr = 14'h2002;
        e.data = 32'(my[i]);
        e.rnd  = RND_Y && rsp;
        sbq.push_back(e);
      end
    end
  endtask

  // One frame: hold the trigger point for 4 clocks, optionally re-trigger
  // mid-sweep or drop en during obstacle 0's x write, then drain.
  task automatic do_frame(input logic [3:0] spd, input logic en_v,
                          input bit retrig, input bit en_drop);
    speed    = spd;
    en       = en_v;
    busy_cnt = 0;
    if (en_v) push_frame(spd, N);
    x = 11'd0;
    y = 11'(V_TRIG);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (en_drop) en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    x = 11'd1;
    y = 11'd0;
    if (retrig) begin
      @(posedge clk); #1;
      x = 11'd0;
      y = 11'(V_TRIG);
      @(posedge clk); #1;
      x = 11'd1;
      y = 11'd0;
    end
    repeat (3 * N + 4) @(posedge clk);
    #1;
    check("sb_drain", 64'(sbq.size()), 64'd0);
    check("busy_cycles", 64'(busy_cnt), en_v ? 64'(3 * N) : 64'd0);
    sbq.delete();
    en = 1'b1;
  endtask

  initial begin
    rows[0]  = '{1,  4'd3,  1'b1, 637, 957};
    rows[1]  = '{1,  4'd0,  1'b1, 637, 957};
    rows[2]  = '{1,  4'd0,  1'b0, 637, 957};
    rows[3]  = '{1,  4'd15, 1'b1, 622, 942};
    rows[4]  = '{41, 4'd15, 1'b1, 7,   327};
    rows[5]  = '{1,  4'd5,  1'b1, 2,   322};
    rows[6]  = '{1,  4'd3,  1'b1, 640, 319};
    rows[7]  = '{42, 4'd15, 1'b1, 10,  340};
    rows[8]  = '{1,  4'd7,  1'b1, 3,   333};
    rows[9]  = '{1,  4'd3,  1'b1, 0,   330};
    rows[10] = '{1,  4'd1,  1'b1, 640, 329};

    for (int i = 0; i < N; i++) last_x[i] = '0;
    model_reset();

    // Reset held with the trigger point and en present.
    reset = 1'b0;
    en    = 1'b1;
    speed = 4'd3;
    x     = 11'd0;
    y     = 11'(V_TRIG);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 64'(cs), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    x     = 11'd1;
    y     = 11'd0;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(busy), 64'd0);

    // Table of frames with known final positions.
    for (int r = 0; r < 11; r++) begin
      for (int k = 0; k < rows[r].reps; k++) do_frame(rows[r].spd, rows[r].en, 1'b0, 1'b0);
      check($sformatf("row%0d_x0", r), 64'(last_x[0]), 64'(rows[r].ex0));
      check($sformatf("row%0d_x1", r), 64'(last_x[1]), 64'(rows[r].ex1));
    end

    // Re-trigger while busy, then en dropped during obstacle 0's x write.
    do_frame(4'd2, 1'b1, 1'b1, 1'b0);
    do_frame(4'd2, 1'b1, 1'b0, 1'b1);

    // Reset during obstacle 0's y write: only the x0 write may appear.
    speed = 4'd4;
    en    = 1'b1;
    push_frame(4'd4, 1);
    x = 11'd0;
    y = 11'(V_TRIG);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    x     = 11'd1;
    y     = 11'd0;
    @(posedge clk); #1;
    check("midrst_write", 64'(write), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sb", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    sbq.delete();
    repeat (10) @(posedge clk);
    #1;
    check("post_midrst_busy", 64'(busy), 64'd0);

    do_frame(4'd3, 1'b1, 1'b0, 1'b0);
    check("after_rst_x0", 64'(last_x[0]), 64'd637);
    check("after_rst_x1", 64'(last_x[1]), 64'd957);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obstacle_motion_sched.md
Name: obstacle_motion_sched

Overview:
- Per-frame motion scheduler for up to N obstacle sprite cores that share one video-slot write bus.
- Once per frame, at vertical-blank start, it sweeps all obstacles in index order:
  - computes each obstacle's new horizontal position;
  - writes x0 then y0 into that core's register space through the slot interface.
- Sits between the frame counter and the obstacle sprite cores; replaces per-frame CPU position writes.

Parameters:
- N, 2, number of obstacles (1..8); width of cs vector.
- H_RES, 640, respawn x when an obstacle leaves the left edge.
- V_TRIG, 480, frame-counter y at which a sweep is triggered.
- X_INIT, 640, reset x of obstacle 0.
- X_SPACING, 320, reset x increment per obstacle index.
- Y_BASE, 400, fixed y0 value written for every obstacle.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset: state clears on a rising clk edge while reset=0.
- x  in  11  frame counter x.
- y  in  11  frame counter y.
- en  in  1  sweep enable.
- speed  in  4  pixels moved left per frame (0 = frozen).
- cs  out  N  one-hot slot select, bit i = obstacle core i.
- write  out  1  slot write strobe.
- addr  out  14  slot address.
- wr_data  out  32  slot write data.
- busy  out  1  high while a sweep is in progress.

Behaviour:
- Trigger:
  - cond = (x==0 && y==V_TRIG), registered into cond_d.
  - trig = cond & ~cond_d, so exactly one pulse per frame regardless of pixel-tick rate.
- FSM states: IDLE, CALC, WR_X, WR_Y.
  - IDLE: trig & en -> CALC, idx=0. Otherwise stay.
  - CALC:
    - sum = {1'b0, xpos[idx]} - speed, 12-bit.
    - If sum[11] (borrow, i.e. xpos < speed): xpos[idx] <= H_RES.
    - Else xpos[idx] <= sum[10:0].
    - Next state WR_X.
  - WR_X:
    - cs = 1<<idx, write=1, addr=14'h2001, wr_data = {21'b0, xpos[idx]}.
    - This is the updated value from CALC.
    - Next state WR_Y.
  - WR_Y:
    - cs = 1<<idx, write=1, addr=14'h2002, wr_data = {21'b0, yval[idx]}.
    - If idx==N-1: -> IDLE. Else idx+1 -> CALC.
- Outputs cs/write/addr/wr_data are registered. Strobes are high for exactly one cycle per write.
- Outside WR_X and WR_Y: cs=0, write=0, addr=0, wr_data=0.
- busy=1 in CALC/WR_X/WR_Y.
- Latency:
  - Trig seen in IDLE at edge t: CALC at t+1, x write visible after edge t+2, y write after t+3.
  - Obstacle i's writes are offset by 3i cycles.
  - Full sweep = 3N cycles.
- Position storage:
  - xpos[i] is 11-bit unsigned; reset value X_INIT + i*X_SPACING, truncated to 11 bits.
  - Exact landing on 0 is kept (0 is valid); only borrow respawns.
- Boundary conditions:
  - trig while busy: ignored, no queuing.
  - en deasserted mid-sweep: current sweep completes; only new sweeps are blocked.
  - speed sampled in each CALC; a change mid-sweep affects only the remaining obstacles.
  - speed=0: writes still occur with unchanged values.
- Reset (reset=0 at an edge):
  - FSM -> IDLE, idx=0, all outputs 0, cond_d=0, xpos/yval back to reset values.
  - Applies mid-sweep too; a partial sweep is abandoned with no further strobes.

Optional Feature:
- Macro: OBSTACLE_RAND_Y_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5 on reset, advances every clk.
  - On a respawn in CALC: yval[idx] <= Y_BASE - {lfsr[5:0]}, so y lies in Y_BASE-63..Y_BASE.
  - yval reset value = Y_BASE.
- Undefined:
  - No LFSR. yval[i] is constant Y_BASE and is always written.

Test Plan:
- Reset: hold reset=0 3 cycles with en=1 and trig conditions present -> cs=0, write=0, addr=0, wr_data=0, busy=0. After release with no trig, no strobes.
- Nominal sweep, N=2, speed=3, en=1:
  - Stimulus: drive y=480, x=0 for 4 clks.
  - Exactly one sweep of 6 cycles, write pulses in order:
    - (cs=01, 2001, 637)
    - (cs=01, 2002, 400)
    - (cs=10, 2001, 957)
    - (cs=10, 2002, 400)
  - busy high exactly 6 cycles.
- Wrap:
  - xpos0 driven to 2 through repeated frames, then speed=3 -> next x write for obstacle 0 is 640.
  - xpos0=3, speed=3 -> write 0, no respawn.
- Busy/enable:
  - Second trig inside a sweep -> no extra writes.
  - en=0 at trig -> no writes.
  - en dropped during WR_X of obstacle 0 -> all 4 writes still issued.
- Reset mid-sweep: reset=0 during WR_Y of obstacle 0 -> no further strobes. Next sweep writes x 637 (from reset position 640, speed 3).
- OBSTACLE_RAND_Y_EN: force respawn of obstacle 0 -> y write is in 337..400 and equals 400 - lfsr[5:0] as predicted by a reference model. Without the macro -> y is 400.
